// File: rtl/ring_sequence_checker.sv
// Monitors a one-hot ring counter: locks onto the rotation, counts revolutions and flags step, pattern and stall errors.
// Latency: 1 cycle; every output is registered from the sample taken at the same edge.
// Backpressure: none; q_in is sampled unconditionally every clock, and hold marks cycles where the counter is paused.
module ring_sequence_checker #(
    parameter int WIDTH    = 4,
    parameter int DIR      = 0,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 4,
    localparam int PH_W    = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WIDTH-1:0]  q_in,
    input  logic              hold,
    output logic              locked,
    output logic              err,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [REV_W-1:0]  rev_cnt,
    output logic [PH_W-1:0]   phase
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   prev;
    logic [3:0]         good_cnt;

    logic               valid;
    logic               match;
    logic               wrap;
    logic               lock_hit;
    logic [WIDTH-1:0]   rot;
    logic [PH_W-1:0]    hot_idx;

    always_comb begin
        valid = $onehot(q_in);
        if (DIR == 0) begin
            rot  = {prev[WIDTH-2:0], prev[WIDTH-1]};
            wrap = prev[WIDTH-1] && q_in[0];
        end else begin
            rot  = {prev[0], prev[WIDTH-1:1]};
            wrap = prev[0] && q_in[WIDTH-1];
        end
        match    = (q_in == (hold ? prev : rot));
        lock_hit = ((good_cnt + 4'd1) == 4'(LOCK_CNT));
        hot_idx  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_in[i]) hot_idx = PH_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            prev       <= '0;
            good_cnt   <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            rev_cnt    <= '0;
            phase      <= '0;
        end else begin
            err <= 1'b0;
            if (valid) phase <= hot_idx;
            case (state)
                // Invalid patterns are expected around clear, so IDLE never flags them.
                IDLE: begin
                    if (valid) begin
                        state    <= ACQ;
                        prev     <= q_in;
                        good_cnt <= '0;
                    end
                end
                ACQ: begin
                    if (match) begin
                        prev     <= q_in;
                        good_cnt <= good_cnt + 4'd1;
                        if (lock_hit) begin
                            state  <= TRACK;
                            locked <= 1'b1;
                        end
                    end else if (valid) begin
                        prev     <= q_in;
                        good_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                TRACK: begin
                    if (match) begin
                        prev <= q_in;
                        if (!hold && wrap) rev_cnt <= rev_cnt + REV_W'(1);
                    end else begin
                        err        <= 1'b1;
                        err_sticky <= 1'b1;
                        locked     <= 1'b0;
                        good_cnt   <= '0;
                        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                        if (valid) begin
                            state <= ACQ;
                            prev  <= q_in;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Bench for ring_sequence_checker: directed scenarios plus random traffic scored against an index-level model.
module tb_ring_sequence_checker;

    localparam int WIDTH    = 4;
    localparam int DIR      = 0;
    localparam int LOCK_CNT = 2;
    localparam int REV_W    = 8;
    localparam int ERR_W    = 4;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic [3:0]       q_in = 4'b0000;
    logic             hold = 1'b0;
    logic             locked;
    logic             err;
    logic             err_sticky;
    logic [3:0]       err_cnt;
    logic [7:0]       rev_cnt;
    logic [1:0]       phase;

    int total = 0;
    int bad   = 0;

    // Reference model: positions are tracked as ring indices, mode 0=idle 1=acquiring 2=tracking.
    int         m_mode = 0;
    int         m_prev = -1;
    int         m_good = 0;
    logic       m_locked = 1'b0;
    logic       m_err = 1'b0;
    logic       m_sticky = 1'b0;
    logic [3:0] m_errcnt = '0;
    logic [7:0] m_revcnt = '0;
    logic [1:0] m_phase = '0;

    ring_sequence_checker #(
        .WIDTH(WIDTH), .DIR(DIR), .LOCK_CNT(LOCK_CNT), .REV_W(REV_W), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .clr(clr), .q_in(q_in), .hold(hold),
        .locked(locked), .err(err), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .rev_cnt(rev_cnt), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic int hot_index(input logic [3:0] q);
        int idx = -1;
        if ($countones(q) == 1) begin
            for (int i = 0; i < WIDTH; i++) if (q[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic int next_index(input int p);
        if (p < 0) return 0;
        return (DIR == 0) ? (p + 1) % WIDTH : (p + WIDTH - 1) % WIDTH;
    endfunction

    task automatic model_update(input logic [3:0] q, input logic h, input logic c);
        int  idx;
        bit  ok;
        if (c) begin
            m_mode = 0; m_prev = -1; m_good = 0;
            m_locked = 0; m_err = 0; m_sticky = 0;
            m_errcnt = '0; m_revcnt = '0; m_phase = '0;
            return;
        end
        idx   = hot_index(q);
        m_err = 0;
        if (idx >= 0) m_phase = 2'(idx);
        ok = (idx >= 0) && (m_prev >= 0) && (idx == (h ? m_prev : next_index(m_prev)));
        case (m_mode)
            0: if (idx >= 0) begin m_mode = 1; m_prev = idx; m_good = 0; end
            1: begin
                if (ok) begin
                    m_prev = idx;
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_mode = 2; m_locked = 1; end
                end else if (idx >= 0) begin
                    m_prev = idx; m_good = 0;
                end else begin
                    m_mode = 0;
                end
            end
            default: begin
                if (ok) begin
                    // A revolution completes when the hot bit crosses from the last position back to the first.
                    if (!h && m_prev == (DIR == 0 ? WIDTH - 1 : 0) && idx == (DIR == 0 ? 0 : WIDTH - 1))
                        m_revcnt = m_revcnt + 8'd1;
                    m_prev = idx;
                end else begin
                    m_err = 1; m_sticky = 1; m_locked = 0;
                    if (m_errcnt != 4'hF) m_errcnt = m_errcnt + 4'd1;
                    if (idx >= 0) begin m_mode = 1; m_prev = idx; m_good = 0; end
                    else m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic step(input logic [3:0] q, input logic h, input logic c);
        q_in = q; hold = h; clr = c;
        @(posedge clk);
        model_update(q, h, c);
        #1;
    endtask

    function automatic logic [3:0] pat(input int idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    task automatic test_reset();
        step(4'b1111, 0, 1);
        step(4'b1111, 0, 1);
        total++;
        if ({locked, err, err_sticky, err_cnt, rev_cnt, phase} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want all zero", {locked, err, err_sticky, err_cnt, rev_cnt, phase});
        end
        step(4'b0000, 0, 0);
        total++;
        if ({locked, err, err_sticky, err_cnt, rev_cnt, phase} !== 17'd0) begin
            bad++;
            $display("FAIL idle_after_release: got %b want all zero", {locked, err, err_sticky, err_cnt, rev_cnt, phase});
        end
    endtask

    task automatic test_lock_and_rev();
        step(4'b0001, 0, 0);
        step(4'b0010, 0, 0);
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL early_lock: locked=%b want 0", locked); end
        step(4'b0100, 0, 0);
        total++;
        if (locked !== 1'b1 || phase !== 2'd2) begin
            bad++; $display("FAIL lock: locked=%b phase=%0d want 1/2", locked, phase);
        end
        step(4'b1000, 0, 0);
        step(4'b0001, 0, 0);
        total++;
        if (rev_cnt !== 8'd1 || phase !== 2'd0 || err !== 1'b0) begin
            bad++; $display("FAIL first_rev: rev=%0d phase=%0d err=%b want 1/0/0", rev_cnt, phase, err);
        end
    endtask

    task automatic test_skip_error();
        step(4'b0100, 0, 0);
        total++;
        if ({err, err_cnt, err_sticky, locked} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL skip_err: err=%b cnt=%0d sticky=%b locked=%b want 1/1/1/0", err, err_cnt, err_sticky, locked);
        end
        step(4'b1000, 0, 0);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_one_cycle: err=%b want 0", err); end
        step(4'b0001, 0, 0);
        total++;
        if (locked !== 1'b1 || err_sticky !== 1'b1 || rev_cnt !== 8'd1) begin
            bad++; $display("FAIL relock: locked=%b sticky=%b rev=%0d want 1/1/1", locked, err_sticky, rev_cnt);
        end
    endtask

    task automatic test_invalid();
        step(4'b0010, 0, 0);
        step(4'b0000, 0, 0);
        total++;
        if (err !== 1'b1 || phase !== 2'd1 || err_cnt !== 4'd2 || locked !== 1'b0) begin
            bad++; $display("FAIL zero_pattern: err=%b phase=%0d cnt=%0d locked=%b want 1/1/2/0", err, phase, err_cnt, locked);
        end
        step(4'b0110, 0, 0);
        total++;
        if (err !== 1'b0 || phase !== 2'd1 || err_cnt !== 4'd2) begin
            bad++; $display("FAIL multi_hot_idle: err=%b phase=%0d cnt=%0d want 0/1/2", err, phase, err_cnt);
        end
        step(4'b0001, 0, 0);
        step(4'b0010, 0, 0);
        step(4'b0100, 0, 0);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL relock_after_idle: locked=%b want 1", locked); end
    endtask

    task automatic test_hold();
        int errs = 0;
        step(4'b1000, 0, 0);
        step(4'b0001, 0, 0);
        step(4'b0010, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 1, 0);
            if (err) errs++;
        end
        total++;
        if (errs != 0 || locked !== 1'b1 || rev_cnt !== 8'd2) begin
            bad++; $display("FAIL hold_match: errs=%0d locked=%b rev=%0d want 0/1/2", errs, locked, rev_cnt);
        end
        step(4'b0100, 1, 0);
        total++;
        if (err !== 1'b1 || err_cnt !== 4'd3) begin
            bad++; $display("FAIL hold_changed: err=%b cnt=%0d want 1/3", err, err_cnt);
        end
        step(4'b1000, 0, 0);
        step(4'b0001, 0, 0);
        step(4'b0001, 0, 0);
        total++;
        if (err !== 1'b1 || err_cnt !== 4'd4 || locked !== 1'b0) begin
            bad++; $display("FAIL stall: err=%b cnt=%0d locked=%b want 1/4/0", err, err_cnt, locked);
        end
    endtask

    task automatic test_err_saturation();
        int pulses = 0;
        for (int i = 0; i < 17; i++) begin
            step(pat(next_index(m_prev)), 0, 0);
            step(pat(next_index(m_prev)), 0, 0);
            step(pat(m_prev), 0, 0);
            if (err) pulses++;
        end
        total++;
        if (err_cnt !== 4'hF || pulses != 17) begin
            bad++; $display("FAIL err_saturate: cnt=%0d pulses=%0d want 15/17", err_cnt, pulses);
        end
    endtask

    task automatic test_rev_wrap();
        int n = 0;
        step(pat(next_index(m_prev)), 0, 0);
        step(pat(next_index(m_prev)), 0, 0);
        while (m_revcnt != 8'd255 && n < 2000) begin
            step(pat(next_index(m_prev)), 0, 0);
            n++;
        end
        total++;
        if (rev_cnt !== 8'd255 || locked !== 1'b1) begin
            bad++; $display("FAIL rev_255: rev=%0d locked=%b want 255/1", rev_cnt, locked);
        end
        n = 0;
        while (m_revcnt == 8'd255 && n < 8) begin
            step(pat(next_index(m_prev)), 0, 0);
            n++;
        end
        total++;
        if (rev_cnt !== 8'd0 || locked !== 1'b1 || n > WIDTH) begin
            bad++; $display("FAIL rev_wrap: rev=%0d locked=%b steps=%0d want 0/1/<=4", rev_cnt, locked, n);
        end
    endtask

    task automatic test_clr_mid_track();
        step(pat(next_index(m_prev)), 0, 0);
        step(4'b0000, 0, 1);
        total++;
        if ({locked, err, err_sticky, err_cnt, rev_cnt, phase} !== 17'd0) begin
            bad++; $display("FAIL clr_mid_track: got %b want all zero", {locked, err, err_sticky, err_cnt, rev_cnt, phase});
        end
    endtask

    task automatic test_random();
        logic [3:0] q;
        logic       h;
        logic       c;
        int         r;
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            h = 1'b0; c = 1'b0;
            if (r < 70)      q = pat(next_index(m_prev));
            else if (r < 80) begin h = 1'b1; q = (m_prev < 0) ? 4'b0001 : pat(m_prev); end
            else if (r < 98) begin h = 1'($urandom_range(0, 1)); q = 4'($urandom_range(0, 15)); end
            else             begin c = 1'b1; q = 4'($urandom_range(0, 15)); end
            step(q, h, c);
            total++;
            if ({locked, err, err_sticky, err_cnt, rev_cnt, phase} !==
                {m_locked, m_err, m_sticky, m_errcnt, m_revcnt, m_phase}) begin
                bad++;
                $display("FAIL random[%0d]: q=%b hold=%b got l=%b e=%b s=%b ec=%0d rc=%0d ph=%0d want l=%b e=%b s=%b ec=%0d rc=%0d ph=%0d",
                         i, q, h, locked, err, err_sticky, err_cnt, rev_cnt, phase,
                         m_locked, m_err, m_sticky, m_errcnt, m_revcnt, m_phase);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_and_rev();
        test_skip_error();
        test_invalid();
        test_hold();
        test_err_saturation();
        test_rev_wrap();
        test_clr_mid_track();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
